// File: rtl/level_sequencer.sv
// Game-flow controller for the three guessing-game levels (easy, medium, hard).
// Starts each level in turn, clears level state between levels, accumulates
// score and declares a win or a loss.
module level_sequencer #(
  parameter int unsigned MAX_GUESSES  = 5,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 50
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [2:0] level_done_i,
  input  logic [8:0] guesses_flat_i,
  output logic [2:0] level_start_o,
  output logic       level_reset_o,
  output logic [1:0] curr_level_o,
  output logic [3:0] score_o,
  output logic       flash_o,
  output logic       game_won_o,
  output logic       game_over_o
);

  localparam int unsigned MaxCycles = (CLEAR_CYCLES > HOLD_CYCLES) ? CLEAR_CYCLES : HOLD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPlay,
    StWinHold,
    StLoseHold,
    StDoneWin,
    StDoneLose
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        curr_level_q, curr_level_d;
  logic [3:0]        score_q, score_d;
  logic [2:0]        level_start_q;
  logic              level_reset_q, flash_q, game_won_q, game_over_q;

  logic              done_sel;
  logic [2:0]        g_sel;
  logic [2:0]        level_onehot;
  logic [2:0]        term;
  logic [4:0]        sum;

  // Select done flag, guess count and enable pattern of the active level.
  always_comb begin
    done_sel     = level_done_i[0];
    g_sel        = guesses_flat_i[2:0];
    level_onehot = 3'b001;
    unique case (curr_level_q)
      2'd1: begin
        done_sel     = level_done_i[1];
        g_sel        = guesses_flat_i[5:3];
        level_onehot = 3'b010;
      end
      2'd2: begin
        done_sel     = level_done_i[2];
        g_sel        = guesses_flat_i[8:6];
        level_onehot = 3'b100;
      end
      default: begin
        done_sel     = level_done_i[0];
        g_sel        = guesses_flat_i[2:0];
        level_onehot = 3'b001;
      end
    endcase
  end

  // Level score: unused guesses, clamped at zero, added with saturation at 15.
  always_comb begin
    term = (g_sel > 3'(MAX_GUESSES)) ? 3'd0 : 3'(MAX_GUESSES) - g_sel;
    sum  = {1'b0, score_q} + {2'b00, term};
  end

  // Next-state logic for state, cycle counter, level index and score.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    curr_level_d = curr_level_q;
    score_d      = score_q;
    unique case (state_q)
      StIdle, StDoneWin, StDoneLose: begin
        if (start_i) begin
          state_d      = StClear;
          curr_level_d = 2'd0;
          score_d      = 4'd0;
        end
      end
      StClear: begin
        if (cnt_q == CntW'(CLEAR_CYCLES - 1)) state_d = StPlay;
      end
      StPlay: begin
        cnt_d = '0;
        // A done flag beats the guess limit when both arrive together.
        if (done_sel) begin
          state_d = StWinHold;
          score_d = (sum > 5'd15) ? 4'd15 : sum[3:0];
        end else if (g_sel >= 3'(MAX_GUESSES)) begin
          state_d = StLoseHold;
        end
      end
      StWinHold: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          if (curr_level_q == 2'd2) begin
            state_d = StDoneWin;
          end else begin
            state_d      = StClear;
            curr_level_d = curr_level_q + 2'd1;
          end
        end
      end
      StLoseHold: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) state_d = StDoneLose;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State and Moore outputs; level_start stays up one cycle past leaving PLAY.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      curr_level_q  <= 2'd0;
      score_q       <= 4'd0;
      level_start_q <= 3'b000;
      level_reset_q <= 1'b0;
      flash_q       <= 1'b0;
      game_won_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      curr_level_q  <= curr_level_d;
      score_q       <= score_d;
      level_start_q <= (state_d == StPlay || state_q == StPlay) ? level_onehot : 3'b000;
      level_reset_q <= (state_d == StClear);
      flash_q       <= (state_d == StWinHold) || (state_d == StLoseHold);
      game_won_q    <= (state_d == StDoneWin);
      game_over_q   <= (state_d == StDoneLose);
    end
  end

  assign level_start_o = level_start_q;
  assign level_reset_o = level_reset_q;
  assign curr_level_o  = curr_level_q;
  assign score_o       = score_q;
  assign flash_o       = flash_q;
  assign game_won_o    = game_won_q;
  assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with MAX_GUESSES=5, CLEAR_CYCLES=2, HOLD_CYCLES=4.
module tb_level_sequencer;

  logic       Clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] done;
  logic [8:0] g;
  logic [2:0] level_start;
  logic       level_reset;
  logic [1:0] curr_level;
  logic [3:0] score;
  logic       flash, game_won, game_over;

  logic [12:0] obs, expv;
  int n_vec = 0;
  int n_err = 0;

  level_sequencer #(
    .MAX_GUESSES (5),
    .CLEAR_CYCLES(2),
    .HOLD_CYCLES (4)
  ) dut (
    .Clk           (Clk),
    .reset         (reset),
    .start_i       (start),
    .level_done_i  (done),
    .guesses_flat_i(g),
    .level_start_o (level_start),
    .level_reset_o (level_reset),
    .curr_level_o  (curr_level),
    .score_o       (score),
    .flash_o       (flash),
    .game_won_o    (game_won),
    .game_over_o   (game_over)
  );

  always #5 Clk = ~Clk;

  assign obs = {level_start, level_reset, curr_level, score, flash, game_won, game_over};

  // Packs expected output values in the same order as obs.
  function automatic logic [12:0] pk(input int ls, input int lr, input int cl, input int sc,
                                     input int fl, input int w, input int o);
    logic [31:0] a, b, c, d, e, f, h;
    a = ls; b = lr; c = cl; d = sc; e = fl; f = w; h = o;
    return {a[2:0], b[0], c[1:0], d[3:0], e[0], f[0], h[0]};
  endfunction

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; done = 3'b000; g = 9'd0;
    tick(); tick();
    expv = pk(0, 0, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL reset: got %h want %h", obs, expv); n_err++; end
    reset = 1'b0;
    tick();
    n_vec++;
    if (obs !== expv) begin $display("FAIL idle_hold: got %h want %h", obs, expv); n_err++; end
  endtask

  task automatic test_start_clear();
    start = 1'b1; tick(); start = 1'b0;
    expv = pk(0, 1, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL clear_c1: got %h want %h", obs, expv); n_err++; end
    tick(); n_vec++;
    if (obs !== expv) begin $display("FAIL clear_c2: got %h want %h", obs, expv); n_err++; end
    tick();
    expv = pk(1, 0, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL play_easy: got %h want %h", obs, expv); n_err++; end
  endtask

  task automatic test_easy_win();
    g = 9'b000_000_001; done = 3'b001;
    tick();
    expv = pk(1, 0, 0, 4, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL easy_win_edge: got %h want %h", obs, expv); n_err++; end
    done = 3'b000; g = 9'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expv = pk(0, 0, 0, 4, 1, 0, 0); n_vec++;
      if (obs !== expv) begin $display("FAIL easy_hold%0d: got %h want %h", i, obs, expv); n_err++; end
    end
    tick();
    expv = pk(0, 1, 1, 4, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL clear_med: got %h want %h", obs, expv); n_err++; end
    tick(); tick();
    expv = pk(2, 0, 1, 4, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL play_med: got %h want %h", obs, expv); n_err++; end
  endtask

  task automatic test_ignore_inactive();
    done = 3'b101; g = {3'd7, 3'd0, 3'd7};
    tick();
    expv = pk(2, 0, 1, 4, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL ignore_inactive: got %h want %h", obs, expv); n_err++; end
    done = 3'b000; g = 9'd0;
  endtask

  task automatic test_med_hard_win();
    done = 3'b010;
    tick();
    expv = pk(2, 0, 1, 9, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL med_win: got %h want %h", obs, expv); n_err++; end
    done = 3'b000;
    tick(); tick(); tick(); tick();
    expv = pk(0, 1, 2, 9, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL clear_hard: got %h want %h", obs, expv); n_err++; end
    tick(); tick();
    expv = pk(4, 0, 2, 9, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL play_hard: got %h want %h", obs, expv); n_err++; end
    g = {3'd2, 6'd0}; done = 3'b100;
    tick();
    expv = pk(4, 0, 2, 12, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL hard_win: got %h want %h", obs, expv); n_err++; end
    done = 3'b000; g = 9'd0;
    tick(); tick(); tick(); tick();
    expv = pk(0, 0, 2, 12, 0, 1, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL done_win: got %h want %h", obs, expv); n_err++; end
    tick(); n_vec++;
    if (obs !== expv) begin $display("FAIL done_win_held: got %h want %h", obs, expv); n_err++; end
  endtask

  task automatic test_lose();
    start = 1'b1; tick(); start = 1'b0;
    expv = pk(0, 1, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL restart_clear: got %h want %h", obs, expv); n_err++; end
    tick(); tick();
    expv = pk(1, 0, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL restart_play: got %h want %h", obs, expv); n_err++; end
    start = 1'b1; tick(); start = 1'b0; n_vec++;
    if (obs !== expv) begin $display("FAIL start_ignored_play: got %h want %h", obs, expv); n_err++; end
    g = 9'd4; tick(); n_vec++;
    if (obs !== expv) begin $display("FAIL g4_stays: got %h want %h", obs, expv); n_err++; end
    g = 9'd5; tick();
    expv = pk(1, 0, 0, 0, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL lose_edge: got %h want %h", obs, expv); n_err++; end
    g = 9'd0; tick();
    expv = pk(0, 0, 0, 0, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL lose_hold: got %h want %h", obs, expv); n_err++; end
    start = 1'b1; tick(); start = 1'b0; n_vec++;
    if (obs !== expv) begin $display("FAIL start_ignored_hold: got %h want %h", obs, expv); n_err++; end
    tick(); tick();
    expv = pk(0, 0, 0, 0, 0, 0, 1); n_vec++;
    if (obs !== expv) begin $display("FAIL done_lose: got %h want %h", obs, expv); n_err++; end
  endtask

  task automatic test_done_and_limit();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    expv = pk(1, 0, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL simul_play: got %h want %h", obs, expv); n_err++; end
    g = 9'd5; done = 3'b001; tick();
    expv = pk(1, 0, 0, 0, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL simul_done_wins: got %h want %h", obs, expv); n_err++; end
    g = 9'd0; done = 3'b000;
    tick(); tick(); tick(); tick();
    expv = pk(0, 1, 1, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL simul_to_clear: got %h want %h", obs, expv); n_err++; end
  endtask

  task automatic test_reset_mid_game();
    tick(); tick();
    expv = pk(2, 0, 1, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL mid_play_med: got %h want %h", obs, expv); n_err++; end
    g = {3'd0, 3'd1, 3'd0}; done = 3'b010; tick();
    expv = pk(2, 0, 1, 4, 1, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL mid_win: got %h want %h", obs, expv); n_err++; end
    g = 9'd0; done = 3'b000; tick();
    reset = 1'b1; tick();
    expv = pk(0, 0, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== expv) begin $display("FAIL reset_mid: got %h want %h", obs, expv); n_err++; end
    reset = 1'b0; tick(); tick(); n_vec++;
    if (obs !== expv) begin $display("FAIL idle_after_reset: got %h want %h", obs, expv); n_err++; end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done = 3'b000; g = 9'd0;
    @(negedge Clk);
    test_reset();
    test_start_clear();
    test_easy_win();
    test_ignore_inactive();
    test_med_hard_win();
    test_lose();
    test_done_and_limit();
    test_reset_mid_game();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
